// File: rtl/k580vt57_pkg.sv
// Shared types and constants for the k580vt57 DMA controller.
package k580vt57_pkg;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_XFER,
        S_UPD
    } state_e;

    // Register map: {ch,0}=address, {ch,1}=count, 8=mode/status.
    localparam logic [3:0] REG_MODE = 4'd8;

    // Mode register bit positions; bits [3:0] are the channel enables.
    localparam int unsigned MODE_ROT    = 4;
    localparam int unsigned MODE_TCSTOP = 6;
    localparam int unsigned MODE_AUTOLD = 7;

    // Transfer type held in count[15:14]; 2'b11 behaves as verify.
    localparam logic [1:0] XT_VERIFY = 2'b00;
    localparam logic [1:0] XT_WRITE  = 2'b01;
    localparam logic [1:0] XT_READ   = 2'b10;

    // Replace the low or high byte of a 16-bit register.
    function automatic logic [15:0] set_byte(input logic [15:0] v, input logic hi,
                                             input logic [7:0] b);
        return hi ? {b, v[7:0]} : {v[15:8], b};
    endfunction

endpackage

// File: rtl/k580vt57_dma_prio_arb.sv
// Combinational 4-way priority encoder, fixed (ch0 first) or rotating
// (channel after last_ch_i first, so last_ch_i ends up lowest).
module dma_prio_arb (
    input  logic [3:0] req_i,
    input  logic       rotate_i,
    input  logic [1:0] last_ch_i,
    output logic [1:0] grant_o,
    output logic       valid_o
);

    logic [1:0] start;
    logic [1:0] idx;

    // Scan the request vector starting from the highest-priority slot.
    always_comb begin
        start   = rotate_i ? last_ch_i + 2'd1 : 2'd0;
        idx     = 2'd0;
        grant_o = 2'd0;
        valid_o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!valid_o && req_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/k580vt57.sv
// 8257-compatible 4-channel DMA controller: register port, arbitration,
// bus hold handshake and transfer sequencing.
module k580vt57
    import k580vt57_pkg::*;
#(
    parameter int unsigned XFER_CYCLES  = 2,
    parameter bit          RESET_ROTATE = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  iaddr,
    input  logic [7:0]  idata,
    output logic [7:0]  odata,
    input  logic        iwe_n,
    input  logic        ird_n,
    input  logic [3:0]  drq,
    output logic [3:0]  dack,
    output logic        hrq,
    input  logic        hlda,
    output logic [15:0] oaddr,
    output logic        memr,
    output logic        memw,
    output logic        ior,
    output logic        iow,
    output logic        tc
);

    localparam logic [2:0] XLAST = 3'(XFER_CYCLES - 1);

    logic [15:0] addr_q [4];
    logic [15:0] addr_d [4];
    logic [15:0] cnt_q  [4];
    logic [15:0] cnt_d  [4];
    logic [7:0]  mode_q, mode_d;
    logic [3:0]  tc_flag_q, tc_flag_d;
    logic        update_q, update_d;
    logic        ff_q, ff_d;
    logic        we_q, rd_q;

    state_e      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [1:0]  last_ch_q, last_ch_d;
    logic [2:0]  xcnt_q, xcnt_d;
    logic        hrq_q, hrq_d;

    logic        wr_ev, rd_ev;
    logic [1:0]  reg_ch;
    logic        is_mode, is_chreg;
    logic        cur_zero;
    logic        in_upd;
    logic [3:0]  arb_req;
    logic        arb_rot;
    logic [1:0]  arb_last;
    logic [1:0]  arb_grant;
    logic        arb_valid;

    // Strobe acts on the 0->1 transition of the CPU strobe.
    assign wr_ev    = !we_q && iwe_n;
    assign rd_ev    = !rd_q && ird_n;
    assign reg_ch   = iaddr[2:1];
    assign is_mode  = (iaddr == REG_MODE);
    assign is_chreg = !iaddr[3];
    assign cur_zero = (cnt_q[ch_q][13:0] == 14'd0);
    assign in_upd   = (state_q == S_UPD);

    // In S_UPD arbitrate against the enables as they will be after this cycle.
    assign arb_req  = in_upd ? (drq & mode_d[3:0]) : (drq & mode_q[3:0]);
    assign arb_rot  = in_upd ? mode_d[MODE_ROT] : mode_q[MODE_ROT];
    assign arb_last = in_upd ? ch_q : last_ch_q;

    dma_prio_arb u_arb (
        .req_i     (arb_req),
        .rotate_i  (arb_rot),
        .last_ch_i (arb_last),
        .grant_o   (arb_grant),
        .valid_o   (arb_valid)
    );

    // Register file next state: channel update first, CPU write overrides it.
    always_comb begin
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        tc_flag_d = tc_flag_q;
        update_d  = update_q;
        ff_d      = ff_q;

        if (rd_ev) begin
            if (is_mode) begin
                tc_flag_d = 4'd0;
            end else if (is_chreg) begin
                ff_d = !ff_q;
            end
        end

        if (in_upd) begin
            addr_d[ch_q]       = addr_q[ch_q] + 16'd1;
            cnt_d[ch_q][13:0]  = cnt_q[ch_q][13:0] - 14'd1;
            if (ch_q == 2'd2) begin
                update_d = 1'b0;
            end
            if (cur_zero) begin
                tc_flag_d[ch_q] = 1'b1;
                if (mode_q[MODE_TCSTOP]) begin
                    mode_d[ch_q] = 1'b0;
                end
                if (ch_q == 2'd2 && mode_q[MODE_AUTOLD]) begin
                    addr_d[2] = addr_q[3];
                    cnt_d[2]  = cnt_q[3];
                    update_d  = 1'b1;
                    mode_d[2] = mode_q[2];
                end
            end
        end

        if (wr_ev) begin
            if (is_mode) begin
                mode_d = idata;
                ff_d   = 1'b0;
            end else if (is_chreg) begin
                ff_d = !ff_q;
                if (iaddr[0]) begin
                    cnt_d[reg_ch] = set_byte(cnt_q[reg_ch], ff_q, idata);
                end else begin
                    addr_d[reg_ch] = set_byte(addr_q[reg_ch], ff_q, idata);
                end
                // Autoload mirrors channel 2 programming into the channel 3 shadow.
                if (reg_ch == 2'd2 && mode_q[MODE_AUTOLD]) begin
                    if (iaddr[0]) begin
                        cnt_d[3] = set_byte(cnt_q[3], ff_q, idata);
                    end else begin
                        addr_d[3] = set_byte(addr_q[3], ff_q, idata);
                    end
                end
            end
        end
    end

    // Transfer sequencer next state.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        last_ch_d = last_ch_q;
        xcnt_d    = xcnt_q;
        hrq_d     = hrq_q;
        unique case (state_q)
            S_IDLE: begin
                hrq_d = 1'b0;
                if (arb_req != 4'd0) begin
                    hrq_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (arb_req == 4'd0) begin
                    hrq_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (hlda && arb_valid) begin
                    ch_d    = arb_grant;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                xcnt_d  = 3'd0;
                state_d = S_XFER;
            end
            S_XFER: begin
                if (xcnt_q == XLAST) begin
                    state_d = S_UPD;
                end else begin
                    xcnt_d = xcnt_q + 3'd1;
                end
            end
            S_UPD: begin
                last_ch_d = ch_q;
                if (hlda && arb_valid) begin
                    ch_d    = arb_grant;
                    state_d = S_ADDR;
                end else begin
                    hrq_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                hrq_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus-side outputs decoded from the current state and active channel.
    always_comb begin
        dack  = 4'd0;
        oaddr = 16'd0;
        memr  = 1'b0;
        memw  = 1'b0;
        ior   = 1'b0;
        iow   = 1'b0;
        tc    = 1'b0;
        hrq   = hrq_q;
        if (state_q == S_ADDR || state_q == S_XFER) begin
            dack[ch_q] = 1'b1;
            oaddr      = addr_q[ch_q];
        end
        if (state_q == S_XFER) begin
            tc = cur_zero;
            case (cnt_q[ch_q][15:14])
                XT_WRITE: begin
                    ior  = 1'b1;
                    memw = 1'b1;
                end
                XT_READ: begin
                    memr = 1'b1;
                    iow  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // CPU read mux: status at 8, selected byte of address/count below 8.
    always_comb begin
        odata = 8'd0;
        if (is_mode) begin
            odata = {3'b000, update_q, tc_flag_q};
        end else if (is_chreg) begin
            if (iaddr[0]) begin
                odata = ff_q ? cnt_q[reg_ch][15:8] : cnt_q[reg_ch][7:0];
            end else begin
                odata = ff_q ? addr_q[reg_ch][15:8] : addr_q[reg_ch][7:0];
            end
        end
    end

    // State and register update; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                addr_q[i] <= 16'd0;
                cnt_q[i]  <= 16'd0;
            end
            mode_q    <= {3'b000, RESET_ROTATE, 4'b0000};
            tc_flag_q <= 4'd0;
            update_q  <= 1'b0;
            ff_q      <= 1'b0;
            we_q      <= 1'b1;
            rd_q      <= 1'b1;
            state_q   <= S_IDLE;
            ch_q      <= 2'd0;
            last_ch_q <= 2'd3;
            xcnt_q    <= 3'd0;
            hrq_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            tc_flag_q <= tc_flag_d;
            update_q  <= update_d;
            ff_q      <= ff_d;
            we_q      <= iwe_n;
            rd_q      <= ird_n;
            state_q   <= state_d;
            ch_q      <= ch_d;
            last_ch_q <= last_ch_d;
            xcnt_q    <= xcnt_d;
            hrq_q     <= hrq_d;
        end
    end

endmodule
